// File: rtl/dram_result_reporter.sv
// Buffers DRAM test-controller events in a small FIFO and streams each one to
// uart_tx as a 12-byte ASCII line "T@AAA:DDDD\r\n".
module dram_result_reporter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_valid,
  input  logic             ev_type,
  input  logic [11:0]      ev_addr,
  input  logic [15:0]      ev_data,
  output logic             ev_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic [7:0]       overflow_cnt,
  output logic             busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int EW    = 29;

  typedef enum logic [1:0] {IDLE, SEND, ACK, DONE} state_t;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0]    frame;
  logic [3:0]       idx;
  logic [7:0]       cur_byte;
  state_t           state;
  logic             push, pop, full;

  // Full test uses the pre-edge count, so a same-edge pop never admits a push.
  assign full     = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign ev_ready = !full;
  assign push     = ev_valid && !full;
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ev_type, ev_addr, ev_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (ev_valid && !push && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // frame = {type, addr[11:0], data[15:0]}
  always_comb begin
    cur_byte = 8'h0A;
    case (idx)
      4'd0:    cur_byte = frame[28] ? 8'h52 : 8'h57;
      4'd1:    cur_byte = 8'h40;
      4'd2:    cur_byte = hex(frame[27:24]);
      4'd3:    cur_byte = hex(frame[23:20]);
      4'd4:    cur_byte = hex(frame[19:16]);
      4'd5:    cur_byte = 8'h3A;
      4'd6:    cur_byte = hex(frame[15:12]);
      4'd7:    cur_byte = hex(frame[11:8]);
      4'd8:    cur_byte = hex(frame[7:4]);
      4'd9:    cur_byte = hex(frame[3:0]);
      4'd10:   cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      frame    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          frame <= mem[rd_ptr];
          idx   <= '0;
          state <= SEND;
        end
        SEND: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= cur_byte;
          state    <= ACK;
        end
        // Wait for the UART to acknowledge before watching for it to go idle.
        ACK: if (tx_busy) state <= DONE;
        DONE: if (!tx_busy) begin
          if (idx == 4'd11) state <= IDLE;
          else begin
            idx   <= idx + 1'b1;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
